// File: rtl/sbox_sched_if.sv
// Bus bundle for sbox_sched: upstream input, shared S-box lookup port,
// downstream output and state visibility.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once valid is raised, the source holds its data stable until
// that edge. Ready may depend on state only, never on valid.
interface sbox_sched_if;
  logic [1:48] data_in;
  logic        in_valid;
  logic        in_ready;
  logic        sbox_req;
  logic [2:0]  sbox_sel;
  logic [1:6]  sbox_in;
  logic [1:4]  sbox_out;
  logic [1:32] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [1:0]  state_dbg;

  modport slave (
    input  data_in, in_valid, sbox_out, out_ready,
    output in_ready, sbox_req, sbox_sel, sbox_in, data_out, out_valid, busy, state_dbg
  );

  modport master (
    output data_in, in_valid, sbox_out, out_ready,
    input  in_ready, sbox_req, sbox_sel, sbox_in, data_out, out_valid, busy, state_dbg
  );
endinterface

// File: rtl/sbox_sched.sv
// Sequencer that runs the eight DES S-box lookups of one round through a
// single shared lookup port, one 6-bit group per cycle, and assembles the
// 32-bit substituted word behind a valid/ready output.
module sbox_sched #(
  parameter int LUT_LAT = 1  // 0: combinational lookup, 1: registered lookup
) (
  input  logic         clk,
  input  logic         rst_n,
  sbox_sched_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:48] din_q, din_d;
  logic [3:0]  iss_cnt_q, iss_cnt_d;
  logic [3:0]  cap_cnt_q, cap_cnt_d;
  logic [1:32] dout_q, dout_d;
  logic        req_q, req_d;
  logic        req_dly_q, req_dly_d;
  logic [2:0]  sel_q, sel_d;
  logic [1:6]  sin_q, sin_d;

  logic [2:0]  nxt_idx;
  logic [5:0]  grp_base;
  logic [5:0]  nib_base;
  logic        cap_fire;

  // The lookup outputs are registered, so each cycle prepares the issue for
  // the following cycle: the issue counter always equals the S-box on the bus.
  assign nxt_idx  = iss_cnt_q[2:0] + 3'd1;
  assign grp_base = {3'b000, nxt_idx} * 6'd6 + 6'd1;
  assign nib_base = {3'b000, cap_cnt_q[2:0]} * 6'd4 + 6'd1;
  // A response is present in the issue cycle (LUT_LAT 0) or one cycle later.
  assign cap_fire = (state_q == S_RUN) && ((LUT_LAT == 0) ? req_q : req_dly_q);

  // Next-state, issue and capture logic.
  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    iss_cnt_d = iss_cnt_q;
    cap_cnt_d = cap_cnt_q;
    dout_d    = dout_q;
    req_d     = 1'b0;
    sel_d     = 3'd0;
    sin_d     = 6'd0;
    req_dly_d = req_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          din_d     = bus.data_in;
          iss_cnt_d = 4'd0;
          cap_cnt_d = 4'd0;
          req_d     = 1'b1;
          sel_d     = 3'd0;
          sin_d     = bus.data_in[1:6];
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (iss_cnt_q < 4'd7) begin
          req_d = 1'b1;
          sel_d = nxt_idx;
          sin_d = din_q[grp_base +: 6];
        end
        if (iss_cnt_q < 4'd8) begin
          iss_cnt_d = iss_cnt_q + 4'd1;
        end
        if (cap_fire) begin
          dout_d[nib_base +: 4] = bus.sbox_out;
          cap_cnt_d = cap_cnt_q + 4'd1;
          if (cap_cnt_q == 4'd7) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      din_q     <= '0;
      iss_cnt_q <= 4'd0;
      cap_cnt_q <= 4'd0;
      dout_q    <= '0;
      req_q     <= 1'b0;
      req_dly_q <= 1'b0;
      sel_q     <= 3'd0;
      sin_q     <= '0;
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      iss_cnt_q <= iss_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      dout_q    <= dout_d;
      req_q     <= req_d;
      req_dly_q <= req_dly_d;
      sel_q     <= sel_d;
      sin_q     <= sin_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.state_dbg = state_q;
  assign bus.sbox_req  = req_q;
  assign bus.sbox_sel  = sel_q;
  assign bus.sbox_in   = sin_q;
  assign bus.data_out  = dout_q;

endmodule

// File: tb/tb_sbox_sched.sv
// Bench for sbox_sched: one instance per lookup latency, DES S-box lookup
// models on the shared port, vector table plus multi-cycle sequences.
module tb_sbox_sched;

  logic clk;
  logic rst_n;

  sbox_sched_if bus0 ();
  sbox_sched_if bus1 ();

  sbox_sched #(.LUT_LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sbox_sched #(.LUT_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // drive / observe arrays indexed by lookup latency
  logic [47:0] drv_din [2];
  logic [1:0]  drv_valid;
  logic [1:0]  drv_ready;
  logic [1:0]  obs_in_ready, obs_out_valid, obs_req, obs_busy;
  logic [2:0]  obs_sel [2];
  logic [31:0] obs_dout [2];
  logic [1:0]  obs_state1;

  assign bus0.data_in   = drv_din[0];
  assign bus0.in_valid  = drv_valid[0];
  assign bus0.out_ready = drv_ready[0];
  assign bus1.data_in   = drv_din[1];
  assign bus1.in_valid  = drv_valid[1];
  assign bus1.out_ready = drv_ready[1];

  assign obs_in_ready  = {bus1.in_ready, bus0.in_ready};
  assign obs_out_valid = {bus1.out_valid, bus0.out_valid};
  assign obs_req       = {bus1.sbox_req, bus0.sbox_req};
  assign obs_busy      = {bus1.busy, bus0.busy};
  assign obs_sel[0]    = bus0.sbox_sel;
  assign obs_sel[1]    = bus1.sbox_sel;
  assign obs_dout[0]   = bus0.data_out;
  assign obs_dout[1]   = bus1.data_out;
  assign obs_state1    = bus1.state_dbg;

  // DES S-box tables, row-major (row*16+col), first entry in the top nibble
  function automatic logic [3:0] des_sbox(input logic [2:0] s, input logic [5:0] v);
    logic [255:0] rom;
    int row, col, n;
    case (s)
      3'd0: rom = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      3'd1: rom = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      3'd2: rom = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      3'd3: rom = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      3'd4: rom = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      3'd5: rom = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
      3'd6: rom = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      default: rom = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    endcase
    row = int'({v[5], v[0]});
    col = int'(v[4:1]);
    n = row * 16 + col;
    return rom[255 - 4 * n -: 4];
  endfunction

  // reference: full-round substitution of a 48-bit block (bit 1 = MSB)
  function automatic logic [31:0] ref_word(input logic [47:0] d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[31 - 4 * k -: 4] = des_sbox(3'(k), d[47 - 6 * k -: 6]);
    end
    return r;
  endfunction

  // lookup port models: garbage whenever no request is outstanding
  logic [3:0] noise;
  always_ff @(posedge clk) noise <= 4'($urandom);

  always_comb begin
    bus0.sbox_out = bus0.sbox_req ? des_sbox(bus0.sbox_sel, bus0.sbox_in) : noise;
  end

  always_ff @(posedge clk) begin
    bus1.sbox_out <= bus1.sbox_req ? des_sbox(bus1.sbox_sel, bus1.sbox_in) : noise;
  end

  // scoreboard
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one job on the chosen instance, out_ready held high; starts and ends at a
  // negedge with the instance idle
  task automatic run_job(input int lat, input logic [47:0] din, input logic [31:0] exp,
                         input string tag);
    int vcyc;
    int bad;
    logic [31:0] got;
    check({tag, "_in_ready"}, 64'(obs_in_ready[lat]), 64'd1);
    drv_din[lat]   = din;
    drv_valid[lat] = 1'b1;
    drv_ready[lat] = 1'b1;
    @(negedge clk);
    drv_valid[lat] = 1'b0;
    bad  = 0;
    vcyc = -1;
    got  = '0;
    for (int i = 1; i <= 20 && vcyc < 0; i++) begin
      if (i <= 8) begin
        if (!obs_req[lat] || obs_sel[lat] != 3'(i - 1)) bad++;
      end else if (obs_req[lat]) begin
        bad++;
      end
      if (obs_out_valid[lat]) begin
        vcyc = i;
        got  = obs_dout[lat];
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_issue_seq"}, 64'(bad), 64'd0);
    check({tag, "_valid_cycle"}, 64'(vcyc), 64'(9 + lat));
    check({tag, "_data"}, 64'(got), 64'(exp));
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(obs_out_valid[lat]), 64'd0);
    check({tag, "_ready_back"}, 64'(obs_in_ready[lat]), 64'd1);
  endtask

  typedef struct {
    int          lat;
    logic [47:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic [47:0] bp_d;
  logic [47:0] jd [3];
  int          acc_cyc [3];
  int          recv_cyc [3];
  int          nacc, nrecv;
  bit          pend;
  bit          seen;

  initial begin
    vecs[0] = '{1, 48'h0, 32'hEFA72C4D};
    vecs[1] = '{0, {48{1'b1}}, 32'hD9CE3DCB};
    vecs[2] = '{0, 48'h0, 32'hEFA72C4D};
    vecs[3] = '{1, {48{1'b1}}, 32'hD9CE3DCB};
    vecs[4] = '{1, 48'h040000000000, 32'h0FA72C4D};
    vecs[5] = '{0, 48'h000000000020, 32'hEFA72C47};
    for (int i = 6; i < 8; i++) begin
      vecs[i].lat = i - 6;
      vecs[i].din = {16'($urandom), 32'($urandom)};
      vecs[i].exp = ref_word(vecs[i].din);
    end

    // reset held two cycles with in_valid high
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      drv_din[d]   = {48{1'b1}};
      drv_valid[d] = 1'b1;
      drv_ready[d] = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("rst_in_ready%0d", d), 64'(obs_in_ready[d]), 64'd1);
        check($sformatf("rst_out_valid%0d", d), 64'(obs_out_valid[d]), 64'd0);
        check($sformatf("rst_data%0d", d), 64'(obs_dout[d]), 64'd0);
        check($sformatf("rst_req%0d", d), 64'(obs_req[d]), 64'd0);
        check($sformatf("rst_busy%0d", d), 64'(obs_busy[d]), 64'd0);
      end
    end
    rst_n = 1'b1;
    drv_valid = 2'b00;
    @(negedge clk);
    check("post_rst_idle", 64'({obs_busy, obs_in_ready}), 64'b0011);

    // table-driven jobs
    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].lat, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // backpressure with in_valid held high
    bp_d = {16'($urandom), 32'($urandom)};
    drv_din[1]   = bp_d;
    drv_valid[1] = 1'b1;
    drv_ready[1] = 1'b0;
    for (int i = 0; i < 30 && !obs_out_valid[1]; i++) @(negedge clk);
    check("bp_valid_rise", 64'(obs_out_valid[1]), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp_data", 64'(obs_dout[1]), 64'(ref_word(bp_d)));
      check("bp_in_ready", 64'(obs_in_ready[1]), 64'd0);
      check("bp_req", 64'(obs_req[1]), 64'd0);
      check("bp_valid", 64'(obs_out_valid[1]), 64'd1);
      @(negedge clk);
    end
    drv_ready[1] = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(obs_in_ready[1]), 64'd1);
    check("bp_release_valid", 64'(obs_out_valid[1]), 64'd0);
    @(negedge clk);
    drv_valid[1] = 1'b0;
    for (int i = 0; i < 30 && !obs_out_valid[1]; i++) @(negedge clk);
    check("bp_second_data", 64'(obs_dout[1]), 64'(ref_word(bp_d)));
    @(negedge clk);

    // reset in cycle c4 of a job
    drv_din[1]   = {16'($urandom), 32'($urandom)};
    drv_valid[1] = 1'b1;
    @(negedge clk);
    drv_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 64'(obs_state1), 64'd0);
    check("mid_rst_in_ready", 64'(obs_in_ready[1]), 64'd1);
    check("mid_rst_req", 64'(obs_req[1]), 64'd0);
    check("mid_rst_valid", 64'(obs_out_valid[1]), 64'd0);
    check("mid_rst_data", 64'(obs_dout[1]), 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (obs_out_valid[1] || obs_busy[1]) seen = 1'b1;
    end
    check("mid_rst_no_out", 64'(seen), 64'd0);
    run_job(1, 48'h0, 32'hEFA72C4D, "post_abort");

    // back-to-back random jobs, in_valid and out_ready held high
    for (int j = 0; j < 3; j++) jd[j] = {16'($urandom), 32'($urandom)};
    drv_din[1]   = jd[0];
    drv_valid[1] = 1'b1;
    drv_ready[1] = 1'b1;
    nacc  = 0;
    nrecv = 0;
    pend  = 1'b0;
    for (int cyc = 0; cyc < 60 && nrecv < 3; cyc++) begin
      if (pend) begin
        pend = 1'b0;
        if (nacc < 3) drv_din[1] = jd[nacc];
        else drv_valid[1] = 1'b0;
      end
      if (obs_out_valid[1]) begin
        recv_cyc[nrecv] = cyc;
        nrecv++;
        if (exp_q.size() == 0) check("b2b_unexpected_out", 64'd1, 64'd0);
        else check("b2b_data", 64'(obs_dout[1]), 64'(exp_q.pop_front()));
      end
      if (obs_in_ready[1] && drv_valid[1] && nacc < 3) begin
        acc_cyc[nacc] = cyc;
        exp_q.push_back(ref_word(drv_din[1]));
        nacc++;
        pend = 1'b1;
      end
      @(negedge clk);
    end
    drv_valid[1] = 1'b0;
    check("b2b_received", 64'(nrecv), 64'd3);
    check("b2b_accepted", 64'(nacc), 64'd3);
    if (nacc == 3 && nrecv == 3) begin
      check("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd11);
      check("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd11);
      check("b2b_latency", 64'(recv_cyc[0] - acc_cyc[0]), 64'd10);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sbox_sched.md
# sbox_sched

Sequencer that evaluates the eight DES S-box substitutions of one round through a single shared S-box lookup port, one 6-bit group per cycle. It sits between the E-expansion/key-XOR stage (48-bit input) and the P-permutation stage (32-bit output) in area-reduced round datapaths. It drives the shared lookup's select and input lines, collects the 4-bit results, and presents the assembled 32-bit word with a valid/ready handshake.

## Interface
- LUT_LAT, 1, lookup response latency in cycles; legal values 0 (combinational lookup) or 1 (registered lookup)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- data_in  input  [1:48]  expanded, key-mixed half block; bits 1..6 go to S1, ..., bits 43..48 go to S8
- in_valid  input  1  data_in is valid
- in_ready  output  1  block can accept data_in
- sbox_req  output  1  lookup issue strobe
- sbox_sel  output  [2:0]  S-box select; 0 = S1, ..., 7 = S8
- sbox_in  output  [1:6]  6-bit lookup input, DES bit order
- sbox_out  input  [1:4]  lookup result, valid LUT_LAT cycles after the matching sbox_req
- data_out  output  [1:32]  substituted word; S1 result in bits 1..4, ..., S8 result in bits 29..32
- out_valid  output  1  data_out is valid
- out_ready  input  1  downstream accepts data_out
- busy  output  1  high in RUN and DONE

## Operation
- Reset (rst_n low at a clock edge) sets state to IDLE, issue and capture counters to 0, data_out to 0, out_valid to 0, sbox_req to 0, sbox_sel to 0, and sbox_in to 0. in_ready is 1 on the cycle after reset.
- Reset mid-operation aborts the job and discards the partial result. No output handshake occurs for an aborted job.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, latch data_in into the input register, clear both counters, and go to RUN.
- RUN:
  - in_ready = 0.
  - While the issue counter is below 8: sbox_req = 1, sbox_sel = the issue counter value, and sbox_in = input bits [6k+1 : 6k+6] for k = the issue counter value. The issue counter increments every cycle.
  - The capture counter tracks responses. Each response is written to data_out bits [4j+1 : 4j+4] for j = the capture counter value, then the capture counter increments.
  - With LUT_LAT = 0, capture happens in the issue cycle. With LUT_LAT = 1, capture happens one cycle after issue, using a delayed copy of sbox_req.
  - After the 8th capture, go to DONE.
  - sbox_req = 0 and sbox_sel/sbox_in hold at 0 whenever no issue is made.
- DONE:
  - out_valid = 1 and data_out stays stable.
  - When out_ready is high, go to IDLE and drop out_valid on the next cycle. data_out keeps its last value until the next capture overwrites it.
- No overlap between jobs: a new input is accepted only in IDLE. in_valid is ignored in RUN and DONE.
- Counters are 4 bits wide. The issue count saturates at 8, and an issue counter value of 8 suppresses sbox_req.

## Timing
- Throughput: one block per 10 + LUT_LAT cycles when out_ready is held high.
- Latency: accept happens in cycle c0. Issues occur in cycles c1..c8 with sbox_sel = 0..7. The last capture is at the end of cycle c8+LUT_LAT. out_valid is first high in cycle c9+LUT_LAT.
- If out_ready is already high when out_valid rises, the handshake completes in that same cycle. in_ready returns high in the following cycle.
- If out_ready is low, out_valid and data_out hold indefinitely.
- All outputs are registered except in_ready, out_valid and busy, which decode state directly.

## Test plan
- Reset: hold rst_n low for 2 cycles with in_valid = 1 → in_ready = 1, out_valid = 0, data_out = 0, sbox_req = 0, busy = 0; no job starts while reset is low.
- All-zero input: data_in = 0, LUT_LAT = 1, bench model of the DES S-boxes, out_ready = 1 → sbox_sel steps 0..7 on cycles c1..c8; out_valid is high in cycle c10 only; data_out = 32'hEFA72C4D.
- All-ones input: data_in = all 1s, LUT_LAT = 0 → out_valid is first high in cycle c9; data_out = 32'hD9CE3DCB.
- Backpressure: out_ready = 0 for 5 cycles after out_valid rises, with in_valid held high → data_out is stable, in_ready = 0 throughout, no sbox_req; after out_ready goes high, in_ready = 1 on the next cycle.
- Mid-job reset: assert rst_n low in cycle c4 → next cycle shows IDLE, sbox_req = 0, out_valid = 0, data_out = 0; a following zero-input job still yields 32'hEFA72C4D.
- Back-to-back: 3 jobs with random data_in and in_valid/out_ready held high → each result matches the bench model; jobs are accepted 11 cycles apart (LUT_LAT = 1).
